// File: rtl/rr_mux_n_pkg.sv
// rtl/rr_mux_n_pkg.sv - shared constants and width helpers for the arbitrated mux
package rr_mux_n_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Grant index is never narrower than one bit, even for degenerate N.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_n_arbiter.sv
// rtl/rr_mux_n_arbiter.sv - combinational round-robin / fixed-priority arbiter
module rr_arbiter
    import rr_mux_n_pkg::*;
#(
    parameter  int N        = 4,
    localparam int SEL_BITS = sel_width(N)
) (
    input  logic [N-1:0]        req,
    input  logic [SEL_BITS-1:0] base,
    input  logic                fixed,
    output logic [N-1:0]        gnt,
    output logic [SEL_BITS-1:0] gnt_idx,
    output logic                any
);

    logic [SEL_BITS-1:0] start;
    logic [N-1:0]        masked;
    logic                found;

    assign start = (fixed == MODE_FIXED) ? '0 : base;
    assign any   = |req;

    always_comb begin
        masked = req;
        for (int i = 0; i < N; i++) begin
            if (i < int'(start)) begin
                masked[i] = 1'b0;
            end
        end
    end

    // Upper half of the double-width scan: masked requests first, then the
    // unmasked copy catches the wrap back below the start index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (masked[i] && !found) begin
                found      = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = SEL_BITS'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found      = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = SEL_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel arbitrated mux with a one-beat output register
module rr_mux_n
    import rr_mux_n_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int N        = 4,
    localparam int SEL_BITS = sel_width(N)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fixed_pri,
    input  logic [N-1:0]          in_valid,
    input  logic [N*WIDTH-1:0]    in_data,
    output logic [N-1:0]          in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_BITS-1:0]   out_grant,
    input  logic                  out_ready
);

    logic [N-1:0]        gnt;
    logic [SEL_BITS-1:0] gnt_idx;
    logic [SEL_BITS-1:0] ptr;
    logic [SEL_BITS-1:0] ptr_next;
    logic                any;
    logic                load_en;
    logic [WIDTH-1:0]    sel_data;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req     (in_valid),
        .base    (ptr),
        .fixed   (fixed_pri),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load_en  = !out_valid || out_ready;
    assign in_ready = load_en ? gnt : '0;

    // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-two N.
    assign ptr_next = (gnt_idx == SEL_BITS'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
        end else if (load_en) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_grant <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load_en && any && (fixed_pri == MODE_RR)) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb/tb_rr_mux_n.sv - randomized self-checking bench for rr_mux_n against a behavioural model
module tb_rr_mux_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        fixed_pri;
    logic        hold_chk;

    logic [3:0]   v4;
    logic [31:0]  d4 [4];
    logic [127:0] data4;
    logic [3:0]   rdy4;
    logic         ov4;
    logic [31:0]  od4;
    logic [1:0]   og4;
    logic         or4;

    logic [2:0]   v3;
    logic [31:0]  d3 [3];
    logic [95:0]  data3;
    logic [2:0]   rdy3;
    logic         ov3;
    logic [31:0]  od3;
    logic [1:0]   og3;
    logic         or3;

    assign data4 = {d4[3], d4[2], d4[1], d4[0]};
    assign data3 = {d3[2], d3[1], d3[0]};

    rr_mux_n #(.WIDTH(32), .N(4)) dut4 (
        .clock(clock), .reset(reset), .fixed_pri(fixed_pri),
        .in_valid(v4), .in_data(data4), .in_ready(rdy4),
        .out_valid(ov4), .out_data(od4), .out_grant(og4), .out_ready(or4)
    );

    rr_mux_n #(.WIDTH(32), .N(3)) dut3 (
        .clock(clock), .reset(reset), .fixed_pri(fixed_pri),
        .in_valid(v3), .in_data(data3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_grant(og3), .out_ready(or3)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: the held beat and the next channel to be favoured.
    logic        m4_valid, m3_valid;
    logic [31:0] m4_data, m3_data;
    int          m4_grant, m3_grant, m4_ptr, m3_ptr;

    function automatic int win(input int n, input logic [3:0] v, input logic fp, input int p);
        int s;
        s = fp ? 0 : p;
        for (int k = 0; k < n; k++) begin
            if (v[(s + k) % n]) return (s + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int n, input logic [3:0] v, input logic fp,
                                             input int p, input logic mv, input logic ordy);
        int w;
        w = win(n, v, fp, p);
        if ((!mv || ordy) && w >= 0) return 4'b0001 << w;
        return 4'b0000;
    endfunction

    task automatic step4();
        int w;
        w = win(4, v4, fixed_pri, m4_ptr);
        if (!m4_valid || or4) begin
            if (w >= 0) begin
                m4_valid = 1'b1;
                m4_data  = d4[w];
                m4_grant = w;
                if (!fixed_pri) m4_ptr = (w + 1) % 4;
            end else begin
                m4_valid = 1'b0;
            end
        end
    endtask

    task automatic step3();
        int w;
        w = win(3, {1'b0, v3}, fixed_pri, m3_ptr);
        if (!m3_valid || or3) begin
            if (w >= 0) begin
                m3_valid = 1'b1;
                m3_data  = d3[w];
                m3_grant = w;
                if (!fixed_pri) m3_ptr = (w + 1) % 3;
            end else begin
                m3_valid = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m4_valid = 1'b0; m4_data = '0; m4_grant = 0; m4_ptr = 0;
        m3_valid = 1'b0; m3_data = '0; m3_grant = 0; m3_ptr = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Producer obligation: a pending, unaccepted request holds valid and data.
    logic [3:0]  pv;
    logic [3:0]  pr;
    logic [31:0] pd [4];
    always @(posedge clock) begin
        if (hold_chk && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr[i]) begin
                    assert (v4[i] && d4[i] == pd[i])
                        else $error("producer hold broken on channel %0d", i);
                end
            end
        end
        pv <= v4;
        pr <= rdy4;
        for (int i = 0; i < 4; i++) pd[i] <= d4[i];
    end

    task automatic test_reset();
        v4 = '0; or4 = 1'b0; fixed_pri = 1'b0;
        apply_reset();
        total++;
        if ({ov4, og4, od4} !== 35'd0) begin
            bad++; $display("FAIL reset_state got v=%b g=%0d d=%h want 0", ov4, og4, od4);
        end
        v4 = 4'b0100; d4[2] = 32'hA5A5_0002;
        @(posedge clock); step4(); #1;
        total++;
        if (ov4 !== 1'b1 || og4 !== 2'd2 || od4 !== 32'hA5A5_0002) begin
            bad++; $display("FAIL load_before_reset got v=%b g=%0d d=%h want 1 2 a5a50002", ov4, og4, od4);
        end
        v4 = '0;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({ov4, og4, od4} !== 35'd0) begin
            bad++; $display("FAIL async_reset got v=%b g=%0d d=%h want 0", ov4, og4, od4);
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        v4 = 4'hf; or4 = 1'b1;
        for (int i = 0; i < 4; i++) d4[i] = $urandom;
        @(negedge clock);
        total++;
        if (rdy4 !== 4'b0001) begin
            bad++; $display("FAIL first_ready got %b want 0001", rdy4);
        end
        @(posedge clock); step4(); #1;
        total++;
        if (ov4 !== 1'b1 || og4 !== 2'd0 || od4 !== d4[0]) begin
            bad++; $display("FAIL first_grant got v=%b g=%0d d=%h want 1 0 %h", ov4, og4, od4, d4[0]);
        end
    endtask

    task automatic test_rr_fair();
        logic [3:0] exp_rdy;
        apply_reset();
        fixed_pri = 1'b0; or4 = 1'b1; v4 = 4'hf;
        for (int i = 0; i < 4; i++) d4[i] = 32'h1000 + 32'(i);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            exp_rdy = exp_ready(4, v4, fixed_pri, m4_ptr, m4_valid, or4);
            total++;
            if (rdy4 !== exp_rdy) begin
                bad++; $display("FAIL rr_ready[%0d] got %b want %b", c, rdy4, exp_rdy);
            end
            @(posedge clock); step4(); #1;
            total++;
            if (ov4 !== 1'b1 || og4 !== 2'(c % 4) || od4 !== 32'h1000 + 32'(c % 4)) begin
                bad++; $display("FAIL rr_seq[%0d] got g=%0d d=%h want g=%0d d=%h",
                                c, og4, od4, c % 4, 32'h1000 + 32'(c % 4));
            end
        end
    endtask

    task automatic test_fixed();
        apply_reset();
        fixed_pri = 1'b1; or4 = 1'b1; v4 = 4'b1010;
        for (int i = 0; i < 4; i++) d4[i] = $urandom;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            total++;
            if (rdy4 !== 4'b0010) begin
                bad++; $display("FAIL fixed_ready[%0d] got %b want 0010", c, rdy4);
            end
            @(posedge clock); step4(); #1;
            total++;
            if (ov4 !== 1'b1 || og4 !== 2'd1 || od4 !== d4[1]) begin
                bad++; $display("FAIL fixed_grant[%0d] got g=%0d d=%h want g=1 d=%h", c, og4, od4, d4[1]);
            end
        end
        fixed_pri = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        apply_reset();
        v4 = 4'b0100; d4[2] = $urandom; held = d4[2]; or4 = 1'b0;
        @(negedge clock);
        total++;
        if (rdy4 !== 4'b0100) begin
            bad++; $display("FAIL bp_first_ready got %b want 0100", rdy4);
        end
        @(posedge clock); step4(); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total++;
            if (rdy4 !== 4'b0000) begin
                bad++; $display("FAIL bp_stall_ready[%0d] got %b want 0000", c, rdy4);
            end
            @(posedge clock); step4(); #1;
            total++;
            if (ov4 !== 1'b1 || og4 !== 2'd2 || od4 !== held) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b g=%0d d=%h want 1 2 %h", c, ov4, og4, od4, held);
            end
        end
        or4 = 1'b1;
        @(negedge clock);
        total++;
        if (rdy4 !== 4'b0100) begin
            bad++; $display("FAIL bp_release_ready got %b want 0100", rdy4);
        end
        @(posedge clock); step4(); #1;
        total++;
        if (ov4 !== m4_valid || og4 !== 2'(m4_grant) || od4 !== m4_data) begin
            bad++; $display("FAIL bp_release_out got v=%b g=%0d want v=%b g=%0d", ov4, og4, m4_valid, m4_grant);
        end
        v4 = '0;
    endtask

    task automatic test_wrap3();
        int want [4];
        logic [3:0] exp_rdy;
        want[0] = 1; want[1] = 2; want[2] = 0; want[3] = 2;
        apply_reset();
        or3 = 1'b1;
        for (int i = 0; i < 3; i++) d3[i] = $urandom;
        for (int c = 0; c < 4; c++) begin
            v3 = (c == 0) ? 3'b010 : 3'b101;
            @(negedge clock);
            exp_rdy = exp_ready(3, {1'b0, v3}, fixed_pri, m3_ptr, m3_valid, or3);
            total++;
            if (rdy3 !== exp_rdy[2:0]) begin
                bad++; $display("FAIL wrap3_ready[%0d] got %b want %b", c, rdy3, exp_rdy[2:0]);
            end
            @(posedge clock); step3(); #1;
            total++;
            if (ov3 !== 1'b1 || og3 !== 2'(want[c]) || od3 !== d3[want[c]]) begin
                bad++; $display("FAIL wrap3_grant[%0d] got g=%0d want g=%0d", c, og3, want[c]);
            end
        end
        v3 = '0;
    endtask

    task automatic test_idle_mode();
        logic [31:0] beat;
        apply_reset();
        fixed_pri = 1'b0; or4 = 1'b1; v4 = 4'b0010;
        for (int i = 0; i < 4; i++) d4[i] = $urandom;
        beat = d4[1];
        @(posedge clock); step4(); #1;
        total++;
        if (ov4 !== 1'b1 || og4 !== 2'd1 || od4 !== beat) begin
            bad++; $display("FAIL idle_load got v=%b g=%0d want 1 1", ov4, og4);
        end
        v4 = '0;
        @(posedge clock); step4(); #1;
        total++;
        if (ov4 !== 1'b0 || og4 !== 2'd1 || od4 !== beat) begin
            bad++; $display("FAIL idle_drain got v=%b g=%0d d=%h want 0 1 %h", ov4, og4, od4, beat);
        end
        fixed_pri = 1'b1; v4 = 4'hf;
        @(posedge clock); step4(); #1;
        total++;
        if (ov4 !== 1'b1 || og4 !== 2'd0) begin
            bad++; $display("FAIL mode_fixed got v=%b g=%0d want 1 0", ov4, og4);
        end
        fixed_pri = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); step4(); #1;
            total++;
            if (ov4 !== 1'b1 || og4 !== 2'(c + 2)) begin
                bad++; $display("FAIL mode_resume[%0d] got g=%0d want %0d", c, og4, c + 2);
            end
        end
        v4 = '0;
    endtask

    task automatic test_random();
        logic [3:0] acc;
        logic [3:0] exp_rdy;
        v4 = '0; acc = '0;
        apply_reset();
        hold_chk = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(v4[i] && !acc[i])) begin
                    v4[i] = ($urandom_range(0, 2) != 0);
                    d4[i] = $urandom;
                end
            end
            or4       = ($urandom_range(0, 3) != 0);
            fixed_pri = ($urandom_range(0, 7) == 0);
            @(negedge clock);
            exp_rdy = exp_ready(4, v4, fixed_pri, m4_ptr, m4_valid, or4);
            acc = rdy4;
            total++;
            if (rdy4 !== exp_rdy) begin
                bad++; $display("FAIL rand_ready[%0d] got %b want %b", c, rdy4, exp_rdy);
            end
            @(posedge clock); step4(); #1;
            total++;
            if (ov4 !== m4_valid || og4 !== 2'(m4_grant) || od4 !== m4_data) begin
                bad++; $display("FAIL rand_out[%0d] got v=%b g=%0d d=%h want v=%b g=%0d d=%h",
                                c, ov4, og4, od4, m4_valid, m4_grant, m4_data);
            end
        end
        hold_chk = 1'b0;
        v4 = '0; fixed_pri = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fixed_pri = 1'b0; hold_chk = 1'b0;
        v4 = '0; or4 = 1'b0; v3 = '0; or3 = 1'b0;
        for (int i = 0; i < 4; i++) d4[i] = '0;
        for (int i = 0; i < 3; i++) d3[i] = '0;
        model_reset();
        test_reset();
        test_rr_fair();
        test_fixed();
        test_backpressure();
        test_wrap3();
        test_idle_mode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- N-channel, WIDTH-bit arbitrated multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the fixed 4:1 select mux. Channel selection is made internally by a round-robin or fixed-priority arbiter, not by an external select.
- The result is held in a one-beat output register.
- Sits between multiple producers (e.g. memory/writeback sources) and a single shared consumer in the CPU datapath.

Parameters:
WIDTH, 32, data width per channel in bits
N, 4, number of input channels; any value >= 2, power of two not required
SEL_BITS, clog2(N) (minimum 1), width of the grant index; derived, not overridden

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
fixed_pri  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
in_valid  input  N  per-channel request/valid
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  N  one-hot or zero; channel i's beat is accepted this cycle
out_valid  output  1  output register holds a beat
out_data  output  WIDTH  registered data of the held beat
out_grant  output  SEL_BITS  index of the channel that supplied the held beat
out_ready  input  1  consumer accepts the held beat when out_valid is high

Behaviour:
- Reset (asynchronous, takes effect immediately): out_valid=0, out_data=0, out_grant=0, rr pointer=0. A held beat is discarded.
- Load condition: load_en = !out_valid | out_ready.
- Arbitration (combinational, each cycle):
  - Round-robin mode: winner = first i with in_valid[i], scanning from pointer upward, wrapping modulo N.
  - Fixed-priority mode: winner = lowest i with in_valid[i].
- in_ready[winner] = load_en & any(in_valid). All other in_ready bits are 0. in_ready is never high for a channel whose in_valid is low.
- Transfer on a clock edge with load_en and any request:
  - out_data <= winner's data; out_grant <= winner; out_valid <= 1.
- Pointer update:
  - Round-robin mode: after a transfer from channel w, pointer <= (w+1) mod N. For w = N-1 it wraps to 0, including when N is not a power of two.
  - Fixed-priority mode: pointer is not modified.
- Drain with no request: if out_ready & out_valid and no in_valid is high, out_valid <= 0. out_data and out_grant hold their stale values.
- Stall: if out_valid & !out_ready, the register holds; all in_ready=0; pointer holds.
- Back-to-back: drain and load in the same cycle are allowed, giving full throughput of one beat per cycle.
- Latency: 1 cycle from the in_valid/in_ready handshake to out_valid.
- Mode change:
  - fixed_pri is sampled combinationally and affects the current cycle's arbitration.
  - The pointer keeps its value across mode changes, so round-robin resumes from the last pointer.
- Inputs never time out. A channel must hold in_valid and in_data stable until its in_ready is seen. This is a producer obligation; the bench checks it with assertions.

Decomposition:
- Shared constants include holds:
  - a clog2 function used to derive SEL_BITS;
  - mode encodings MODE_RR=1'b0 and MODE_FIXED=1'b1.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs: req[N], base[SEL_BITS], fixed;
  - outputs: one-hot gnt[N], gnt_idx[SEL_BITS], any.
  - It is purely combinational, implemented as a double-width masked priority scan.
- rr_mux_n instantiates rr_arbiter and owns:
  - the data select (AND-OR of one-hot gnt across in_data slices);
  - the output register;
  - the pointer register.

Test Plan:
1. Reset: assert reset mid-transfer with out_valid=1 -> out_valid, out_data, out_grant go to 0 immediately, without waiting for a clock edge. After release, the first grant goes to channel 0 when all channels request.
2. Round-robin fairness: N=4, all in_valid=1, out_ready=1, data of channel i = 0x1000+i -> out_grant sequence 0,1,2,3,0 on consecutive cycles; out_data 0x1000..0x1003, 0x1000.
3. Fixed priority: fixed_pri=1, in_valid=4'b1010 held, out_ready=1 -> every beat has out_grant=1. Channel 3 is never granted while channel 1 is valid.
4. Backpressure: out_ready=0 for 3 cycles with in_valid=4'b0100 -> out_valid=1, out_grant=2, out_data stable, all in_ready=0 throughout. When out_ready rises, the beat drains and in_ready[2]=1 in that same cycle.
5. Wrap with non-power-of-two N: N=3, pointer at 2, in_valid=3'b101 -> grant 2, then grant 0. Pointer never takes value 3.
6. Idle drain and mode switch: a single beat on channel 1 is drained with no further requests -> out_valid=0 next cycle. Then switch to fixed_pri=1, grant once, switch back to round-robin -> scan resumes from the pointer preserved before the switch.
